// File: rtl/simd_seq_ctrl.sv
// Program sequencer for the SIMD datapath: walks the instruction BRAM from a start PC,
// hides the BRAM read latency and hands each instruction over on a valid/ready handshake.
module simd_seq_ctrl #(
   parameter int                        INS_ADDR_WIDTH = 8,
   parameter int                        INS_WIDTH      = 64,
   parameter int                        OPCODE_WIDTH   = 4,
   parameter int                        OPCODE_LSB     = 30,
   parameter logic [OPCODE_WIDTH-1:0]   HALT_OPCODE    = 4'hF,
   parameter int                        RD_LATENCY     = 2,
   parameter int                        CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start,
   input  logic                      abort,
   input  logic [INS_ADDR_WIDTH-1:0] start_pc,
   output logic [INS_ADDR_WIDTH-1:0] pc,
   input  logic [INS_WIDTH-1:0]      ins_rdata,
   output logic                      issue_valid,
   input  logic                      issue_ready,
   output logic [INS_WIDTH-1:0]      issue_ins,
   output logic                      busy,
   output logic                      done,
   output logic [1:0]                status,
   output logic [CNT_WIDTH-1:0]      ins_count,
   output logic [CNT_WIDTH-1:0]      cycle_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] ST_NONE  = 2'b00;
   localparam logic [1:0] ST_HALT  = 2'b01;
   localparam logic [1:0] ST_OVF   = 2'b10;
   localparam logic [1:0] ST_ABORT = 2'b11;

   // Wait-counter value on the FETCH cycle whose ins_rdata is valid for the held pc.
   localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

   state_t                    state, state_nxt;
   logic [2:0]                wait_cnt, wait_cnt_nxt;
   logic [INS_ADDR_WIDTH-1:0] pc_nxt;
   logic [INS_WIDTH-1:0]      issue_ins_nxt;
   logic [1:0]                status_nxt;
   logic [CNT_WIDTH-1:0]      ins_count_nxt, cycle_count_nxt;
   logic                      issue_valid_nxt, busy_nxt, done_nxt;
   logic [OPCODE_WIDTH-1:0]   opcode;

   assign opcode = ins_rdata[OPCODE_LSB +: OPCODE_WIDTH];

   // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latches).
   always_comb begin
      state_nxt       = state;
      wait_cnt_nxt    = wait_cnt;
      pc_nxt          = pc;
      issue_ins_nxt   = issue_ins;
      status_nxt      = status;
      ins_count_nxt   = ins_count;
      cycle_count_nxt = cycle_count;

      if ((state == FETCH || state == ISSUE) && cycle_count != '1)
         cycle_count_nxt = cycle_count + 1'b1;

      case (state)
         IDLE, DONE: begin
            // start takes priority over a coincident abort here; abort alone is ignored.
            if (start) begin
               state_nxt       = FETCH;
               pc_nxt          = start_pc;
               wait_cnt_nxt    = '0;
               status_nxt      = ST_NONE;
               ins_count_nxt   = '0;
               cycle_count_nxt = '0;
            end
         end

         FETCH: begin
            if (abort) begin
               state_nxt  = DONE;
               status_nxt = ST_ABORT;
            end else if (wait_cnt == LAT_LAST) begin
               if (opcode == HALT_OPCODE) begin
                  state_nxt  = DONE;
                  status_nxt = ST_HALT;
               end else begin
                  state_nxt     = ISSUE;
                  issue_ins_nxt = ins_rdata;
               end
            end else begin
               wait_cnt_nxt = wait_cnt + 3'd1;
            end
         end

         ISSUE: begin
            // Abort wins over a same-cycle handshake, so that instruction is not counted.
            if (abort) begin
               state_nxt  = DONE;
               status_nxt = ST_ABORT;
            end else if (issue_ready) begin
               ins_count_nxt = ins_count + 1'b1;
               if (pc == '1) begin
                  state_nxt  = DONE;
                  status_nxt = ST_OVF;
               end else begin
                  state_nxt    = FETCH;
                  pc_nxt       = pc + 1'b1;
                  wait_cnt_nxt = '0;
               end
            end
         end

         default: state_nxt = IDLE;
      endcase

      // Flag outputs are registered copies of the next-state decode.
      issue_valid_nxt = (state_nxt == ISSUE);
      busy_nxt        = (state_nxt == FETCH) || (state_nxt == ISSUE);
      done_nxt        = (state_nxt == DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         pc          <= '0;
         issue_ins   <= '0;
         issue_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         status      <= ST_NONE;
         ins_count   <= '0;
         cycle_count <= '0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         pc          <= pc_nxt;
         issue_ins   <= issue_ins_nxt;
         issue_valid <= issue_valid_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         status      <= status_nxt;
         ins_count   <= ins_count_nxt;
         cycle_count <= cycle_count_nxt;
      end
   end

endmodule

// File: tb/tb_simd_seq_ctrl.sv
// Directed bench for simd_seq_ctrl with a 2-cycle instruction BRAM model.
module tb_simd_seq_ctrl;
   localparam int AW = 8;
   localparam int IW = 64;
   localparam int CW = 32;

   localparam logic [IW-1:0] ADD0 = 64'hA5A5_0000_4000_0010;
   localparam logic [IW-1:0] ADD1 = 64'hA5A5_0000_4000_0011;
   localparam logic [IW-1:0] ADD2 = 64'hA5A5_0000_4000_0012;
   localparam logic [IW-1:0] HALT = 64'h5A5A_0003_C000_0099;
   localparam logic [IW-1:0] PAST = 64'hA5A5_0000_4000_0014;
   localparam logic [IW-1:0] TOP0 = 64'hC0DE_0000_8000_00FE;
   localparam logic [IW-1:0] TOP1 = 64'hC0DE_0000_8000_00FF;

   logic          clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0, issue_ready = 1'b0;
   logic [AW-1:0] start_pc = '0;
   logic [AW-1:0] pc;
   logic [IW-1:0] ins_rdata, issue_ins, rd_q;
   logic          issue_valid, busy, done;
   logic [1:0]    status;
   logic [CW-1:0] ins_count, cycle_count;
   logic [IW-1:0] mem [0:255];
   int            n_checks = 0, n_fail = 0, cyc = 0;
   int            t0, t1, t2;

   simd_seq_ctrl dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .start_pc(start_pc),
      .pc(pc), .ins_rdata(ins_rdata), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_ins(issue_ins), .busy(busy), .done(done), .status(status),
      .ins_count(ins_count), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   // One register stage: data for an address driven at edge T is valid between T+1 and T+2.
   always @(posedge clk) rd_q <= mem[pc];
   always @(posedge clk) cyc <= cyc + 1;
   assign ins_rdata = rd_q;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_run(input logic [AW-1:0] spc);
      start    = 1'b1;
      start_pc = spc;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output int when);
      int k = 0;
      while (!issue_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_valid"}, 64'(issue_valid), 64'd1);
      when = cyc;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (!done && k < 60) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_done"}, 64'(done), 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pc"},    64'(pc), 64'd0);
      check({tag, "_valid"}, 64'(issue_valid), 64'd0);
      check({tag, "_ins"},   64'(issue_ins), 64'd0);
      check({tag, "_busy"},  64'(busy), 64'd0);
      check({tag, "_done"},  64'(done), 64'd0);
      check({tag, "_stat"},  64'(status), 64'd0);
      check({tag, "_icnt"},  64'(ins_count), 64'd0);
      check({tag, "_ccnt"},  64'(cycle_count), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = ADD0;
      mem[8'h11] = ADD1;
      mem[8'h12] = ADD2;
      mem[8'h13] = HALT;
      mem[8'h14] = PAST;
      mem[8'hFE] = TOP0;
      mem[8'hFF] = TOP1;

      // Reset state, then abort while idle must do nothing.
      repeat (2) @(negedge clk);
      check_all_zero("rst");
      rstn = 1'b1;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("idle_abort_busy", 64'(busy), 64'd0);
      check("idle_abort_done", 64'(done), 64'd0);

      // Three ADDs then HALT, ready tied high; a second start mid-run is ignored.
      issue_ready = 1'b1;
      start_run(8'h10);
      check("b_busy", 64'(busy), 64'd1);
      check("b_pc0", 64'(pc), 64'h10);
      wait_valid("b_i0", t0);
      check("b_ins0", 64'(issue_ins), 64'(ADD0));
      start    = 1'b1;
      start_pc = 8'h40;
      @(negedge clk);
      start    = 1'b0;
      check("b_ignore_pc", 64'(pc), 64'h11);
      wait_valid("b_i1", t1);
      check("b_ins1", 64'(issue_ins), 64'(ADD1));
      check("b_gap01", 64'(t1 - t0), 64'd3);
      @(negedge clk);
      wait_valid("b_i2", t2);
      check("b_ins2", 64'(issue_ins), 64'(ADD2));
      check("b_gap12", 64'(t2 - t1), 64'd3);
      wait_done("b");
      check("b_busy_end", 64'(busy), 64'd0);
      check("b_valid_end", 64'(issue_valid), 64'd0);
      check("b_pc_end", 64'(pc), 64'h13);
      check("b_status", 64'(status), 64'd1);
      check("b_icnt", 64'(ins_count), 64'd3);
      check("b_ccnt", 64'(cycle_count), 64'd11);

      // Restart from DONE; stall the second instruction for five cycles.
      start_run(8'h10);
      check("c_busy", 64'(busy), 64'd1);
      check("c_done_clr", 64'(done), 64'd0);
      check("c_icnt_clr", 64'(ins_count), 64'd0);
      check("c_ccnt_clr", 64'(cycle_count), 64'd0);
      check("c_stat_clr", 64'(status), 64'd0);
      wait_valid("c_i0", t0);
      check("c_ins0", 64'(issue_ins), 64'(ADD0));
      @(negedge clk);
      issue_ready = 1'b0;
      wait_valid("c_i1", t1);
      check("c_ins1", 64'(issue_ins), 64'(ADD1));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("c_stall_valid", 64'(issue_valid), 64'd1);
         check("c_stall_ins", 64'(issue_ins), 64'(ADD1));
         check("c_stall_pc", 64'(pc), 64'h11);
      end
      issue_ready = 1'b1;
      @(negedge clk);
      wait_valid("c_i2", t2);
      check("c_ins2", 64'(issue_ins), 64'(ADD2));
      wait_done("c");
      check("c_status", 64'(status), 64'd1);
      check("c_icnt", 64'(ins_count), 64'd3);
      check("c_ccnt", 64'(cycle_count), 64'd16);

      // PC overflow at the top of the address space; abort in DONE is ignored.
      start_run(8'hFE);
      wait_valid("d_i0", t0);
      check("d_ins0", 64'(issue_ins), 64'(TOP0));
      @(negedge clk);
      wait_valid("d_i1", t1);
      check("d_ins1", 64'(issue_ins), 64'(TOP1));
      wait_done("d");
      check("d_status", 64'(status), 64'd2);
      check("d_pc_end", 64'(pc), 64'hFF);
      check("d_icnt", 64'(ins_count), 64'd2);
      check("d_ccnt", 64'(cycle_count), 64'd6);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("d_abort_ign_stat", 64'(status), 64'd2);
      check("d_abort_ign_done", 64'(done), 64'd1);

      // Abort coinciding with the second handshake.
      start_run(8'h10);
      wait_valid("e_i0", t0);
      @(negedge clk);
      wait_valid("e_i1", t1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("e_valid_low", 64'(issue_valid), 64'd0);
      check("e_status", 64'(status), 64'd3);
      check("e_icnt", 64'(ins_count), 64'd1);
      check("e_done", 64'(done), 64'd1);
      check("e_busy", 64'(busy), 64'd0);
      check("e_ccnt", 64'(cycle_count), 64'd6);

      // Reset while stalled in ISSUE clears outputs immediately.
      issue_ready = 1'b0;
      start_run(8'h10);
      wait_valid("f_i0", t0);
      rstn = 1'b0;
      #1;
      check_all_zero("f_rst");
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // start and abort together from IDLE: start wins, run completes normally.
      issue_ready = 1'b1;
      abort = 1'b1;
      start_run(8'h10);
      abort = 1'b0;
      check("f_start_wins", 64'(busy), 64'd1);
      check("f_stat0", 64'(status), 64'd0);
      wait_done("f");
      check("f_status", 64'(status), 64'd1);
      check("f_icnt", 64'(ins_count), 64'd3);
      check("f_ccnt", 64'(cycle_count), 64'd11);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/simd_seq_ctrl.md
# simd_seq_ctrl

Program sequencer for the SIMD datapath. Takes a start command from the PS, steps the instruction-BRAM read address from a given start PC, and absorbs the BRAM read latency. Presents each fetched instruction to the datapath on a valid/ready handshake and stops on a HALT opcode, PC overflow or abort. Reports busy/done/status and run counters back to the PS.

## Interface
- INS_ADDR_WIDTH, 8, instruction BRAM address width
- INS_WIDTH, 64, instruction word width
- OPCODE_WIDTH, 4, opcode field width
- OPCODE_LSB, 30, bit position of opcode LSB within instruction word
- HALT_OPCODE, 4'hF, opcode that terminates the program
- RD_LATENCY, 2, cycles from address change to valid ins_rdata; legal range 1..7
- CNT_WIDTH, 32, width of run counters

- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle run request; honoured only in IDLE or DONE
- abort  in  1  terminate current run; ignored when not busy
- start_pc  in  INS_ADDR_WIDTH  first instruction address, sampled with start
- pc  out  INS_ADDR_WIDTH  instruction BRAM read address
- ins_rdata  in  INS_WIDTH  instruction BRAM read data
- issue_valid  out  1  issue_ins holds an instruction for the datapath
- issue_ready  in  1  datapath accepts issue_ins this cycle
- issue_ins  out  INS_WIDTH  registered instruction to datapath
- busy  out  1  run in progress (FETCH or ISSUE)
- done  out  1  run finished; held until next accepted start
- status  out  2  termination cause: 00 none, 01 HALT, 10 PC overflow, 11 abort
- ins_count  out  CNT_WIDTH  instructions accepted by datapath this run
- cycle_count  out  CNT_WIDTH  cycles spent busy this run, saturating

## Operation
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE/DONE + start: pc←start_pc, counters←0, status←00, done←0, wait counter←0, go to FETCH.
- FETCH: pc held stable; wait counter increments each cycle. On the RD_LATENCY-th FETCH cycle, ins_rdata is sampled:
  - opcode = ins_rdata[OPCODE_LSB +: OPCODE_WIDTH].
  - opcode == HALT_OPCODE: go to DONE with status 01. HALT is not issued and not counted.
  - Otherwise: issue_ins←ins_rdata, go to ISSUE.
- ISSUE: issue_valid=1. issue_ins is stable until the handshake completes. On issue_valid&&issue_ready, ins_count increments, then:
  - pc == all-ones: go to DONE with status 10 (no wrap).
  - Otherwise: pc←pc+1, go to FETCH.
- abort in FETCH or ISSUE: go to DONE with status 11 next cycle.
  - Abort beats a same-cycle handshake; that instruction is not counted.
  - issue_valid is low from the next cycle.
- start while busy: ignored. abort in IDLE/DONE: ignored. start and abort together in IDLE/DONE: start wins.
- DONE: done=1, busy=0. pc, status and counters hold their values.
- cycle_count increments every cycle busy=1 and saturates at all-ones. ins_count wraps (cannot exceed 2^INS_ADDR_WIDTH per run).

## Timing
- Reset (async assert, sync release): state IDLE; pc=0, issue_valid=0, issue_ins=0, busy=0, done=0, status=00, ins_count=0, cycle_count=0.
- Start accepted at edge T: busy=1 and pc=start_pc visible after T.
- First instruction: issue_valid rises RD_LATENCY cycles after pc is driven.
- With issue_ready tied high, each instruction occupies RD_LATENCY+1 cycles: RD_LATENCY in FETCH plus 1 in ISSUE.
- Stall: issue_valid remains asserted while issue_ready=0. issue_ins and pc are unchanged.
- HALT: busy falls and done rises one cycle after the sampling FETCH cycle.
- All outputs are registered. There is no combinational path from issue_ready or abort to any output.

## Test plan
- Reset mid-run: drive rstn low in ISSUE → all outputs 0 immediately, state IDLE. A start after release runs normally.
- start_pc=0x10, program = 3 ADD words then HALT at 0x13, RD_LATENCY=2, ready=1 → 3 issues in order, 3 cycles apart. Final pc=0x13, status=01, ins_count=3, cycle_count=11, done=1.
- Same program with issue_ready low for 5 cycles on the 2nd instruction → issue_ins stable throughout, ins_count=3, cycle_count=16.
- start_pc=0xFE, no HALT at 0xFE/0xFF → 2 issues, status=10, pc=0xFF, ins_count=2.
- abort asserted in the same cycle as the 2nd handshake → status=11, ins_count=1. issue_valid is 0 the next cycle.
- Second start pulse while busy → ignored, run unaffected. start in DONE → counters clear, done=0, new run begins from the new start_pc.
